// File: rtl/led_pattern_ctrl_if.sv
// Mode-register write bus and lamp-test request for the front-panel LED controller.
interface led_pattern_ctrl_if #(
    parameter int unsigned SEL_W = 2
) ();
    logic             ModeWr;
    logic [SEL_W-1:0] ModeSel;
    logic [2:0]       ModeData;
    logic             LampTestReq;

    modport master (
        output ModeWr,
        output ModeSel,
        output ModeData,
        output LampTestReq
    );

    modport slave (
        input ModeWr,
        input ModeSel,
        input ModeData,
        input LampTestReq
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel bicolor front-panel LED controller: per-channel pattern modes,
// sticky fault latches with red fast blink, and a green-then-red lamp test.
// All blink timing is derived from the 16 ms strobe; pins are active low.
module led_pattern_ctrl #(
    parameter int unsigned NUM_LED    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SLOW_TICKS = 31,
    parameter int unsigned FAST_TICKS = 8,
    parameter int unsigned LAMP_TICKS = 62
) (
    input  logic               SlowClock,
    input  logic               Reset,
    input  logic               Strobe16ms,
    input  logic               PwrEn,
    led_pattern_ctrl_if.slave  bus,
    input  logic [NUM_LED-1:0] FaultIn,
    input  logic [NUM_LED-1:0] FaultClr,
    output logic [NUM_LED-1:0] LED_G_N,
    output logic [NUM_LED-1:0] LED_R_N,
    output logic [NUM_LED-1:0] FaultSt,
    output logic               LampTestBusy
);

    localparam int unsigned SLOW_W = (SLOW_TICKS > 1) ? $clog2(SLOW_TICKS) : 1;
    localparam int unsigned FAST_W = (FAST_TICKS > 1) ? $clog2(FAST_TICKS) : 1;
    localparam int unsigned LAMP_W = (LAMP_TICKS > 1) ? $clog2(LAMP_TICKS) : 1;

    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_TICKS - 1);
    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_TICKS - 1);
    localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTestG,
        StTestR
    } lamp_state_e;

    logic [SLOW_W-1:0]  slow_cnt_q, slow_cnt_d;
    logic [FAST_W-1:0]  fast_cnt_q, fast_cnt_d;
    logic               slow_ph_q, slow_ph_d;
    logic               fast_ph_q, fast_ph_d;
    logic [2:0]         mode_q [NUM_LED];
    logic [2:0]         mode_d [NUM_LED];
    logic [NUM_LED-1:0] fault_q, fault_d;
    lamp_state_e        state_q, state_d;
    logic [LAMP_W-1:0]  lamp_cnt_q, lamp_cnt_d;
    logic               pwr_q, pwr_d;
    logic [NUM_LED-1:0] led_g_n_q, led_g_n_d;
    logic [NUM_LED-1:0] led_r_n_q, led_r_n_d;

    // Pattern for a mode code, returned as {green_lit, red_lit}; phase 0 is the lit half.
    function automatic logic [1:0] mode_lit(input logic [2:0] mode, input logic slow_ph,
                                            input logic fast_ph);
        logic [1:0] lit;
        unique case (mode)
            3'b000:  lit = 2'b00;
            3'b001:  lit = 2'b10;
            3'b010:  lit = 2'b01;
            3'b011:  lit = 2'b11;
            3'b100:  lit = {~slow_ph, 1'b0};
            3'b101:  lit = {1'b0, ~slow_ph};
            3'b110:  lit = {~fast_ph, fast_ph};
            3'b111:  lit = {~fast_ph, 1'b0};
            default: lit = 2'b00;
        endcase
        return lit;
    endfunction

    // Free-running slow/fast blink dividers, advanced only by the strobe.
    always_comb begin
        slow_cnt_d = slow_cnt_q;
        slow_ph_d  = slow_ph_q;
        fast_cnt_d = fast_cnt_q;
        fast_ph_d  = fast_ph_q;
        if (Strobe16ms) begin
            if (slow_cnt_q == SLOW_LAST) begin
                slow_cnt_d = '0;
                slow_ph_d  = ~slow_ph_q;
            end else begin
                slow_cnt_d = slow_cnt_q + SLOW_W'(1);
            end
            if (fast_cnt_q == FAST_LAST) begin
                fast_cnt_d = '0;
                fast_ph_d  = ~fast_ph_q;
            end else begin
                fast_cnt_d = fast_cnt_q + FAST_W'(1);
            end
        end
    end

    // Mode register writes (out-of-range selects match no channel) and fault latches.
    always_comb begin
        mode_d = mode_q;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            if (bus.ModeWr && (bus.ModeSel == SEL_W'(i))) begin
                mode_d[i] = bus.ModeData;
            end
        end
        // Set wins over clear.
        fault_d = FaultIn | (fault_q & ~FaultClr);
        pwr_d   = PwrEn;
    end

    // Lamp-test sequencer next state; power-off aborts from any state.
    always_comb begin
        state_d    = state_q;
        lamp_cnt_d = lamp_cnt_q;
        if (!PwrEn) begin
            state_d    = StIdle;
            lamp_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.LampTestReq) begin
                        state_d    = StTestG;
                        lamp_cnt_d = '0;
                    end
                end
                StTestG: begin
                    if (Strobe16ms) begin
                        if (lamp_cnt_q == LAMP_LAST) begin
                            state_d    = StTestR;
                            lamp_cnt_d = '0;
                        end else begin
                            lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
                        end
                    end
                end
                StTestR: begin
                    if (Strobe16ms) begin
                        if (lamp_cnt_q == LAMP_LAST) begin
                            state_d    = StIdle;
                            lamp_cnt_d = '0;
                        end else begin
                            lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    lamp_cnt_d = '0;
                end
            endcase
        end
    end

    // Pin values from current state: power-off > lamp test > fault > mode.
    always_comb begin
        led_g_n_d = '1;
        led_r_n_d = '1;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            logic [1:0] lit;
            lit = 2'b00;
            if (!pwr_q) begin
                lit = 2'b00;
            end else if (state_q == StTestG) begin
                lit = 2'b10;
            end else if (state_q == StTestR) begin
                lit = 2'b01;
            end else if (fault_q[i]) begin
                lit = {1'b0, ~fast_ph_q};
            end else begin
                lit = mode_lit(mode_q[i], slow_ph_q, fast_ph_q);
            end
            led_g_n_d[i] = ~lit[1];
            led_r_n_d[i] = ~lit[0];
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge SlowClock) begin
        if (Reset) begin
            slow_cnt_q <= '0;
            fast_cnt_q <= '0;
            slow_ph_q  <= 1'b0;
            fast_ph_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                mode_q[i] <= 3'b000;
            end
            fault_q    <= '0;
            state_q    <= StIdle;
            lamp_cnt_q <= '0;
            pwr_q      <= 1'b0;
            led_g_n_q  <= '1;
            led_r_n_q  <= '1;
        end else begin
            slow_cnt_q <= slow_cnt_d;
            fast_cnt_q <= fast_cnt_d;
            slow_ph_q  <= slow_ph_d;
            fast_ph_q  <= fast_ph_d;
            mode_q     <= mode_d;
            fault_q    <= fault_d;
            state_q    <= state_d;
            lamp_cnt_q <= lamp_cnt_d;
            pwr_q      <= pwr_d;
            led_g_n_q  <= led_g_n_d;
            led_r_n_q  <= led_r_n_d;
        end
    end

    assign LED_G_N      = led_g_n_q;
    assign LED_R_N      = led_r_n_q;
    assign FaultSt      = fault_q;
    assign LampTestBusy = (state_q != StIdle);

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised multi-channel bicolor front-panel LED controller. Each channel has a per-channel mode register selecting solid, blink or alternate patterns, plus a sticky fault latch that overrides the mode. A lamp-test sequencer drives all green, then all red. All blink timing derives from the 16 ms slow-clock strobe. It sits alongside the system/PSU/fan LED logic and drives the active-low LED pins directly.

Parameters:
NUM_LED, 4, number of bicolor LED channels (1..16)
SEL_W, 2, width of ModeSel; must satisfy 2**SEL_W >= NUM_LED
SLOW_TICKS, 31, Strobe16ms pulses per slow-blink half-period (~0.5 s)
FAST_TICKS, 8, Strobe16ms pulses per fast-blink half-period (~128 ms)
LAMP_TICKS, 62, Strobe16ms pulses per lamp-test phase (~1 s)

Ports:
SlowClock  in  1  32,768 Hz clock
Reset  in  1  synchronous, active-high reset
Strobe16ms  in  1  single-SlowClock pulse every 16 ms
PwrEn  in  1  1 = power switch on; 0 forces all LEDs off
ModeWr  in  1  one-cycle write strobe for a mode register
ModeSel  in  SEL_W  channel index for the write
ModeData  in  3  mode code to write
LampTestReq  in  1  one-cycle lamp-test start request
FaultIn  in  NUM_LED  per-channel fault, level
FaultClr  in  NUM_LED  per-channel fault-latch clear, pulse
LED_G_N  out  NUM_LED  green drive, active low
LED_R_N  out  NUM_LED  red drive, active low
FaultSt  out  NUM_LED  latched fault status
LampTestBusy  out  1  high while the lamp test runs

Behaviour:
- One clock (SlowClock). Reset is synchronous and active-high.
- Reset values: all mode registers 000; fault latches 0; both counters 0; both phases 0; FSM IDLE; LED_G_N/LED_R_N all 1; FaultSt 0; LampTestBusy 0.
- Tick counters (slow and fast are independent):
  - Counters advance only on Strobe16ms.
  - If cnt == N-1: cnt <= 0 and phase toggles. Otherwise cnt <= cnt+1.
  - Phase 0 = "lit". The first toggle occurs on the N-th strobe after reset.
  - Counters run regardless of PwrEn.
- Mode codes (G,R lit):
  - 000 off
  - 001 green
  - 010 red
  - 011 amber (both lit)
  - 100 green slow blink
  - 101 red slow blink
  - 110 green/red alternate on fast phase (green when phase 0, red when phase 1)
  - 111 green fast blink
- Mode write:
  - On ModeWr with ModeSel < NUM_LED, mode[ModeSel] <= ModeData.
  - ModeSel >= NUM_LED: write ignored.
- Fault latch, per channel:
  - FaultIn[i]=1 sets latch[i].
  - FaultClr[i]=1 with FaultIn[i]=0 clears latch[i].
  - FaultIn and FaultClr both high: set wins (latch stays 1).
  - While latch[i]=1, channel i shows red fast blink (G off, R lit on fast phase 0), overriding its mode.
  - FaultSt = latch.
- Lamp-test FSM, states IDLE, TEST_G, TEST_R:
  - IDLE -> TEST_G on LampTestReq while PwrEn=1. The tick count is cleared on entry.
  - TEST_G: all G lit, R off. After LAMP_TICKS strobes -> TEST_R, tick count cleared.
  - TEST_R: all R lit, G off. After LAMP_TICKS strobes -> IDLE.
  - LampTestReq while not IDLE is ignored.
  - PwrEn=0 in any state -> IDLE next cycle.
  - LampTestBusy = (state != IDLE).
  - The lamp test overrides faults and modes. Fault latches continue to set and clear during the test.
- Priority for a channel's output: PwrEn=0 (both off) > lamp test > fault latch > mode.
- Latency:
  - LED outputs are registered from the current register/FSM state.
  - A ModeWr/FaultIn/LampTestReq sampled at edge k is visible on the pins after edge k+1.
  - PwrEn falling blanks the pins after edge k+1.
- Reset mid-blink or mid-test returns everything to reset values on the next edge. No residual pattern remains.
- Mode registers and fault latches are retained while PwrEn=0. Only the outputs are blanked.

Test Plan:
- Reset, PwrEn=1, no writes -> all LED_*_N=1, FaultSt=0, LampTestBusy=0; counters reach 0 after any Reset pulse mid-run.
- Write mode 100 to ch1, strobe every cycle (SLOW_TICKS=31) -> LED_G_N[1] toggles every 31 strobes, starting lit (0) two edges after ModeWr; LED_R_N[1]=1 throughout.
- Ch2 mode 001; FaultIn[2]=1 for one cycle -> FaultSt[2]=1, ch2 red blink every 8 strobes; FaultClr[2] together with FaultIn[2]=1 keeps the latch; FaultClr alone -> green solid again.
- LampTestReq, LAMP_TICKS=62 -> Busy=1, all G=0 for 62 strobes, all R=0 for 62 strobes, Busy=0 and normal patterns resume; a second request mid-test has no effect.
- Lamp test running, PwrEn dropped -> next edge FSM IDLE, all outputs 1; PwrEn restored -> modes and fault patterns reappear unchanged.
- ModeWr with ModeSel=3 when NUM_LED=3 -> no register changes; NUM_LED=1 build elaborates and works.
